// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU MEM stage / DMA loader) arbiter in front of a
// single-port data memory with fixed 1-cycle read latency.
// The CPU has priority. When the macro DMEM_ARB_STARVE_EN is defined, a
// saturating wait counter lets a starved DMA request win one cycle once it
// has waited STARVE_LIMIT cycles. With the macro undefined, priority is
// strictly CPU-first.
module dmem_arbiter #(
   parameter int DATA_W       = 19,
   parameter int ADDR_W       = 19,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   // CPU (MEM stage) port
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   // DMA / loader port
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   // single-port data memory command / response
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic              cpu_gnt_s;
   logic              dma_gnt_s;
   logic              dma_win_s;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [DATA_W-1:0] mem_wdata_s;
   logic              cpu_rvalid_r;
   logic              dma_rvalid_r;

`ifdef DMEM_ARB_STARVE_EN
   localparam logic [3:0] starve_lim_c = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt_r;

   // Count consecutive cycles the DMA waits; saturate at the limit, clear on grant or idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_r <= 4'd0;
      end else if (dma_req && !dma_gnt_s) begin
         if (starve_cnt_r < starve_lim_c) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end else begin
         starve_cnt_r <= 4'd0;
      end
   end

   assign dma_win_s = dma_req && (starve_cnt_r == starve_lim_c);
`else
   assign dma_win_s = 1'b0;
`endif

   // Pick at most one requester this cycle; nothing is granted while in reset.
   always_comb begin
      cpu_gnt_s = 1'b0;
      dma_gnt_s = 1'b0;
      if (reset) begin
         cpu_gnt_s = 1'b0;
         dma_gnt_s = 1'b0;
      end else if (dma_win_s) begin
         dma_gnt_s = 1'b1;
      end else if (cpu_req) begin
         cpu_gnt_s = 1'b1;
      end else if (dma_req) begin
         dma_gnt_s = 1'b1;
      end else begin
         cpu_gnt_s = 1'b0;
         dma_gnt_s = 1'b0;
      end
   end

   // Steer the granted requester's command onto the memory bus; idle bus is all zero.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_addr_s  = {ADDR_W{1'b0}};
      mem_wdata_s = {DATA_W{1'b0}};
      case ({cpu_gnt_s, dma_gnt_s})
         2'b10: begin
            mem_we_s    = cpu_we;
            mem_addr_s  = cpu_addr;
            mem_wdata_s = cpu_wdata;
         end
         2'b01: begin
            mem_we_s    = dma_we;
            mem_addr_s  = dma_addr;
            mem_wdata_s = dma_wdata;
         end
         default: begin
            mem_we_s    = 1'b0;
            mem_addr_s  = {ADDR_W{1'b0}};
            mem_wdata_s = {DATA_W{1'b0}};
         end
      endcase
   end

   // Remember which port issued a read so its data is flagged next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_rvalid_r <= 1'b0;
         dma_rvalid_r <= 1'b0;
      end else begin
         cpu_rvalid_r <= cpu_gnt_s && !cpu_we;
         dma_rvalid_r <= dma_gnt_s && !dma_we;
      end
   end

   // A reset arriving in the response cycle drops the pending read outright.
   assign cpu_rvalid = cpu_rvalid_r && !reset;
   assign dma_rvalid = dma_rvalid_r && !reset;
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : {DATA_W{1'b0}};
   assign dma_rdata  = dma_rvalid ? mem_rdata : {DATA_W{1'b0}};

   assign cpu_gnt    = cpu_gnt_s;
   assign dma_gnt    = dma_gnt_s;
   assign cpu_stall  = cpu_req && !cpu_gnt_s;
   assign mem_en     = cpu_gnt_s || dma_gnt_s;
   assign mem_we     = mem_we_s;
   assign mem_addr   = mem_addr_s;
   assign mem_wdata  = mem_wdata_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural single-port memory
// (1-cycle read latency; drives junk on mem_rdata when no read is pending).
module tb_dmem_arbiter;

   localparam int DW = 19;
   localparam int AW = 19;

   logic          clk;
   logic          reset;
   logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          dma_req, dma_we, dma_gnt, dma_rvalid;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata, dma_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic [DW-1:0] mem_model [0:15];

   int passed;
   int total;

   logic [5:0] cpu_pat;
   logic [5:0] dma_pat;

   dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural memory: write on enable+we, registered read otherwise junk
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         mem_model[mem_addr[3:0]] <= mem_wdata;
         mem_rdata <= 19'h7FFFF;
      end else if (mem_en) begin
         mem_rdata <= mem_model[mem_addr[3:0]];
      end else begin
         mem_rdata <= 19'h7FFFF;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // invariants checked at every sample point
   task automatic chk_bus(input string tag);
      chk({tag, "_no_overlap"}, {31'd0, cpu_gnt & dma_gnt}, 32'd0);
      chk({tag, "_mem_en"}, {31'd0, mem_en}, {31'd0, cpu_gnt | dma_gnt});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
   endtask

   // both ports hold read requests for six cycles; compare against patterns
   task automatic contention_run(input string tag);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'd0;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 19'd1;
      for (int i = 0; i < 6; i++) begin
         sample();
         chk_bus(tag);
         chk({tag, "_cpu_gnt"}, {31'd0, cpu_gnt}, {31'd0, cpu_pat[i]});
         chk({tag, "_dma_gnt"}, {31'd0, dma_gnt}, {31'd0, dma_pat[i]});
         chk({tag, "_cpu_stall"}, {31'd0, cpu_stall}, {31'd0, ~cpu_pat[i]});
         if (i > 0) begin
            chk({tag, "_cpu_rvalid"}, {31'd0, cpu_rvalid}, {31'd0, cpu_pat[i-1]});
            chk({tag, "_dma_rvalid"}, {31'd0, dma_rvalid}, {31'd0, dma_pat[i-1]});
            chk({tag, "_cpu_rdata"}, {13'd0, cpu_rdata}, cpu_pat[i-1] ? 32'h111 : 32'h0);
            chk({tag, "_dma_rdata"}, {13'd0, dma_rdata}, dma_pat[i-1] ? 32'h222 : 32'h0);
         end else begin
            chk({tag, "_cpu_rvalid0"}, {31'd0, cpu_rvalid}, 32'd0);
            chk({tag, "_dma_rvalid0"}, {31'd0, dma_rvalid}, 32'd0);
         end
         next_cycle();
      end
      idle_inputs();
      sample();
      chk({tag, "_tail_cpu_rdata"}, {13'd0, cpu_rdata}, 32'h111);
      next_cycle();
   endtask

   initial begin
      passed = 0;
      total  = 0;
      for (int k = 0; k < 16; k++) mem_model[k] = 19'd0;
      mem_model[0] = 19'h00111;
      mem_model[1] = 19'h00222;
      mem_model[2] = 19'h00333;
      mem_model[5] = 19'h1ABCD;
      mem_rdata = 19'h7FFFF;
`ifdef DMEM_ARB_STARVE_EN
      cpu_pat = 6'b101111;
      dma_pat = 6'b010000;
`else
      cpu_pat = 6'b111111;
      dma_pat = 6'b000000;
`endif

      // reset with both ports requesting
      idle_inputs();
      reset = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
      sample();
      chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
      chk("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd1);
      next_cycle();
      sample();
      chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      chk("rst_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
      chk("rst_cpu_rdata", {13'd0, cpu_rdata}, 32'd0);
      next_cycle();

      // CPU-only read of addr 5
      reset = 1'b0; idle_inputs();
      cpu_req = 1'b1; cpu_addr = 19'd5;
      sample();
      chk_bus("rd5");
      chk("rd5_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      chk("rd5_mem_addr", {13'd0, mem_addr}, 32'd5);
      chk("rd5_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rd5_cpu_stall", {31'd0, cpu_stall}, 32'd0);
      next_cycle();
      idle_inputs();
      sample();
      chk_bus("rd5b");
      chk("rd5_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      chk("rd5_cpu_rdata", {13'd0, cpu_rdata}, 32'h1ABCD);
      chk("rd5_cpu_stall2", {31'd0, cpu_stall}, 32'd0);
      chk("rd5_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
      chk("rd5_dma_rdata", {13'd0, dma_rdata}, 32'd0);
      chk("idle_mem_addr", {13'd0, mem_addr}, 32'd0);
      next_cycle();

      // CPU write addr 3 data 7 vs DMA read addr 3
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd3; cpu_wdata = 19'd7;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 19'd3;
      sample();
      chk_bus("wr3");
      chk("wr3_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      chk("wr3_dma_gnt", {31'd0, dma_gnt}, 32'd0);
      chk("wr3_mem_we", {31'd0, mem_we}, 32'd1);
      chk("wr3_mem_addr", {13'd0, mem_addr}, 32'd3);
      chk("wr3_mem_wdata", {13'd0, mem_wdata}, 32'd7);
      next_cycle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = 19'd0;
      sample();
      chk_bus("dr3");
      chk("dr3_dma_gnt", {31'd0, dma_gnt}, 32'd1);
      chk("dr3_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
      chk("dr3_mem_we", {31'd0, mem_we}, 32'd0);
      chk("dr3_mem_addr", {13'd0, mem_addr}, 32'd3);
      chk("wr3_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      next_cycle();
      idle_inputs();
      sample();
      chk_bus("dr3b");
      chk("dr3_dma_rvalid", {31'd0, dma_rvalid}, 32'd1);
      chk("dr3_dma_rdata", {13'd0, dma_rdata}, 32'd7);
      chk("dr3_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      next_cycle();

      // sustained contention: starvation window or strict priority
      contention_run("starve");

      // DMA read granted, then reset in the response cycle
      dma_req = 1'b1; dma_addr = 19'd1;
      sample();
      chk("rr_dma_gnt", {31'd0, dma_gnt}, 32'd1);
      next_cycle();
      reset = 1'b1; cpu_req = 1'b1;
      sample();
      chk("rr_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
      chk("rr_dma_rdata", {13'd0, dma_rdata}, 32'd0);
      chk("rr_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
      chk("rr_dma_gnt0", {31'd0, dma_gnt}, 32'd0);
      chk("rr_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rr_cpu_stall", {31'd0, cpu_stall}, 32'd1);
      next_cycle();
      reset = 1'b0; idle_inputs();
      sample();
      chk("rr_no_replay", {31'd0, dma_rvalid}, 32'd0);
      chk("rr_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      next_cycle();

      // counter restarts from zero after reset
      contention_run("post_rst");

      // back-to-back CPU reads of addr 0,1,2
      cpu_req = 1'b1; cpu_addr = 19'd0;
      sample();
      chk_bus("b2b0");
      chk("b2b0_gnt", {31'd0, cpu_gnt}, 32'd1);
      next_cycle();
      cpu_addr = 19'd1;
      sample();
      chk_bus("b2b1");
      chk("b2b1_gnt", {31'd0, cpu_gnt}, 32'd1);
      chk("b2b1_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      chk("b2b1_rdata", {13'd0, cpu_rdata}, 32'h111);
      next_cycle();
      cpu_addr = 19'd2;
      sample();
      chk_bus("b2b2");
      chk("b2b2_gnt", {31'd0, cpu_gnt}, 32'd1);
      chk("b2b2_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      chk("b2b2_rdata", {13'd0, cpu_rdata}, 32'h222);
      next_cycle();
      idle_inputs();
      sample();
      chk_bus("b2b3");
      chk("b2b3_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      chk("b2b3_rdata", {13'd0, cpu_rdata}, 32'h333);
      next_cycle();
      sample();
      chk("b2b4_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      chk("b2b4_rdata", {13'd0, cpu_rdata}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 19, data word width.
REQ-002 Parameter ADDR_W, default 19, data-memory address width.
REQ-003 Parameter STARVE_LIMIT, default 4, legal 1..15, DMA starvation threshold in cycles.
REQ-004 Port clk  in  1  single clock; all state on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port cpu_req / cpu_we  in  1 each  MEM-stage access request / write enable.
REQ-007 Port cpu_addr  in  ADDR_W, cpu_wdata  in  DATA_W  CPU access address / store data.
REQ-008 Port cpu_gnt  out  1  CPU access issued to memory this cycle.
REQ-009 Port cpu_stall  out  1  pipeline stall request to the hazard logic.
REQ-010 Port cpu_rvalid  out  1, cpu_rdata  out  DATA_W  CPU load data valid / value.
REQ-011 Ports dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same widths and meanings as the CPU set, for the loader/DMA port.
REQ-012 Ports mem_en, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W: single-port data memory command.
REQ-013 Port mem_rdata  in  DATA_W  memory read data, valid one cycle after a read command.

Function
REQ-014 At most one grant per cycle; cpu_gnt and dma_gnt shall never both be 1.
REQ-015 Grants are combinational from the current requests and registered arbiter state; mem_en equals cpu_gnt OR dma_gnt.
REQ-016 mem_we, mem_addr and mem_wdata shall be driven from the granted requester; with no grant, mem_we = 0 and mem_addr/mem_wdata = 0.
REQ-017 A requester shall hold req, we, addr and wdata stable until its gnt; the arbiter does not latch requests.
REQ-018 Default priority: CPU wins when both request.
REQ-019 cpu_stall = cpu_req AND NOT cpu_gnt.
REQ-020 A granted read (gnt=1, we=0) asserts that requester's rvalid for exactly the next cycle; rdata = mem_rdata in that cycle.
REQ-021 A granted write produces no rvalid.
REQ-022 rdata outputs are 0 whenever the corresponding rvalid is 0.
REQ-023 Back-to-back grants are allowed every cycle; read latency is fixed at 1 cycle for both ports.
REQ-024 A request on a port that is not granted has no effect on memory or on that port's rvalid.

Reset
REQ-025 While reset = 1: cpu_gnt, dma_gnt, mem_en, mem_we = 0 regardless of requests; cpu_stall = cpu_req.
REQ-026 On the clock edge with reset = 1: cpu_rvalid, dma_rvalid = 0; starvation counter = 0.
REQ-027 Reset asserted in the cycle after a granted read suppresses that rvalid; the read is dropped, not replayed.

Configuration
REQ-028 Macro DMEM_ARB_STARVE_EN, when defined, compiles in DMA starvation protection.
REQ-029 With it: a 4-bit counter increments each cycle dma_req=1 and dma_gnt=0, saturating at STARVE_LIMIT; it clears when dma_gnt=1 or dma_req=0.
REQ-030 With it: when counter == STARVE_LIMIT and dma_req=1, DMA wins over CPU that cycle (cpu_stall asserts if cpu_req=1).
REQ-031 Without it: no counter exists; strict CPU priority, and DMA may starve indefinitely.

Verification
REQ-032 CPU-only read: cpu_req=1, we=0, addr=5, memory holds 19'h1ABCD -> cpu_gnt=1 same cycle, next cycle cpu_rvalid=1, cpu_rdata=19'h1ABCD, cpu_stall=0.
REQ-033 Simultaneous requests, CPU write addr=3 data=7, DMA read addr=3 -> cycle 1 cpu_gnt, dma_gnt=0; cycle 2 dma_gnt; cycle 3 dma_rvalid=1, dma_rdata=7.
REQ-034 Starvation (macro defined, STARVE_LIMIT=4): cpu_req and dma_req held high -> cpu_gnt cycles 1-4, dma_gnt cycle 5 with cpu_stall=1, cpu_gnt resumes cycle 6; undefined -> dma_gnt never while cpu_req=1.
REQ-035 Reset mid-read: DMA read granted, reset=1 next cycle -> dma_rvalid=0, all grants 0 during reset, counter 0 afterwards.
REQ-036 Back-to-back CPU reads of addr 0,1,2 on consecutive cycles -> cpu_rvalid high 3 consecutive cycles with matching data in order; no gnt overlap checked every cycle.
